// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline-register stages.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 64;
  localparam int unsigned PIPE_CTRL_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline register: ctrl + data with load enable,
// synchronous discard and asynchronous clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register between two CPU stages: 2-entry skid buffer
// with flopped in_ready (SKID=1) or single-entry stall register (SKID=0).
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic              r_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Next state and slot steering; flush overrides every handshake.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_load = 1'b1;
          end else if (w_in_xfer) begin
            if (SKID != 0) begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_TWO;
            end
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (flush),
    .i_ctrl  (w_main_ctrl_in),
    .i_data  (w_main_data_in),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (flush),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );

      // Flopped ready: no combinational path from out_ready to in_ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_stall
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
      assign in_ready    = !r_out_valid || out_ready;
    end
  endgenerate

  // Bubbles carry all-zero control so they never write state downstream.
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_valid ? w_main_ctrl : '0;
  assign out_data  = w_main_data;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: SKID=1 and SKID=0 builds driven in parallel,
// checked against directed tables and a queue-based reference model.
module tb_pipe_stage_skid_reg;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          flush;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl1;
  logic [DW-1:0] out_data1;
  logic          in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl0;
  logic [DW-1:0] out_data0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: each stage is an in-order FIFO with a capacity rule.
  ent_t q1[$];
  ent_t q0[$];

  typedef struct {
    logic          iv;
    logic          fl;
    logic          ordy;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          e_ov;
    logic          e_ir;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready1();
    return q1.size() < 2;
  endfunction

  function automatic logic m_ready0();
    return (q0.size() == 0) || out_ready;
  endfunction

  task automatic check_model();
    chk("skid1.in_ready", 64'(in_ready1), 64'(m_ready1()));
    chk("skid1.out_valid", 64'(out_valid1), 64'(q1.size() != 0));
    if (q1.size() != 0) begin
      chk("skid1.out_ctrl", 64'(out_ctrl1), 64'(q1[0].c));
      chk("skid1.out_data", out_data1, q1[0].d);
    end else begin
      chk("skid1.out_ctrl_bubble", 64'(out_ctrl1), 64'(0));
    end
    chk("stall0.in_ready", 64'(in_ready0), 64'(m_ready0()));
    chk("stall0.out_valid", 64'(out_valid0), 64'(q0.size() != 0));
    if (q0.size() != 0) begin
      chk("stall0.out_ctrl", 64'(out_ctrl0), 64'(q0[0].c));
      chk("stall0.out_data", out_data0, q0[0].d);
    end else begin
      chk("stall0.out_ctrl_bubble", 64'(out_ctrl0), 64'(0));
    end
  endtask

  task automatic drive(input logic iv, input logic fl, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
  endtask

  // One clock: check against model, predict transfers, advance model.
  task automatic cycle();
    logic x1, x0, o1, o0, fl;
    ent_t e;
    #1;
    check_model();
    e.c = in_ctrl;
    e.d = in_data;
    fl  = flush;
    x1  = in_valid && m_ready1();
    x0  = in_valid && m_ready0();
    o1  = (q1.size() != 0) && out_ready;
    o0  = (q0.size() != 0) && out_ready;
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (o1) void'(q1.pop_front());
      if (x1) q1.push_back(e);
      if (o0) void'(q0.pop_front());
      if (x0) q0.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic iv, input logic fl, input logic ordy,
                              input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic e_ov, input logic e_ir,
                              input logic [CW-1:0] e_ctrl, input logic [DW-1:0] e_data);
    vec_t v;
    v.iv = iv; v.fl = fl; v.ordy = ordy; v.c = c; v.d = d;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_ctrl = e_ctrl; v.e_data = e_data;
    return v;
  endfunction

  initial begin
    // Streaming 1..8: output trails input by one cycle with no bubbles.
    for (int i = 1; i <= 8; i++) begin
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, CW'(8'h10 + i), DW'(i),
                       (i > 1), 1'b1, (i > 1) ? CW'(8'h10 + i - 1) : CW'(0), DW'(i - 1)));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hFF, 64'h0, 1'b1, 1'b1, 8'h18, 64'd8));
    // Bubbles with junk control must present zero control.
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hFF, 64'hDEAD, 1'b0, 1'b1, 8'h00, 64'h0));
    end
    // Backpressure: A then B with out_ready low, then drain.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h2A, 64'hA, 1'b0, 1'b1, 8'h00, 64'h0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h2B, 64'hB, 1'b1, 1'b1, 8'h2A, 64'hA));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'h0, 1'b1, 1'b0, 8'h2A, 64'hA));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'h0, 1'b1, 1'b0, 8'h2A, 64'hA));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hFF, 64'h0, 1'b1, 1'b0, 8'h2A, 64'hA));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hFF, 64'h0, 1'b1, 1'b1, 8'h2B, 64'hB));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hFF, 64'h0, 1'b0, 1'b1, 8'h00, 64'h0));

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("reset.out_valid1", 64'(out_valid1), 64'(0));
    chk("reset.out_ctrl1", 64'(out_ctrl1), 64'(0));
    chk("reset.in_ready1", 64'(in_ready1), 64'(1));
    chk("reset.out_data1", out_data1, 64'h0);
    chk("reset.out_valid0", 64'(out_valid0), 64'(0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].c, tbl[i].d);
      #1;
      chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid1), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.in_ready", i), 64'(in_ready1), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d.out_ctrl", i), 64'(out_ctrl1), 64'(tbl[i].e_ctrl));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d.out_data", i), out_data1, tbl[i].e_data);
      cycle();
    end

    // Flush while full with a same-cycle input C.
    drive(1'b1, 1'b0, 1'b0, 8'h31, 64'h31); cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h32, 64'h32); cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h33, 64'hC);
    #1;
    chk("flush.head_valid", 64'(out_valid1), 64'(1));
    chk("flush.head_data", out_data1, 64'h31);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 64'h0);
    #1;
    chk("postflush.out_valid1", 64'(out_valid1), 64'(0));
    chk("postflush.out_ctrl1", 64'(out_ctrl1), 64'(0));
    chk("postflush.in_ready1", 64'(in_ready1), 64'(1));
    chk("postflush.in_ready0", 64'(in_ready0), 64'(1));
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h00, 64'h0);
      #1;
      chk("postflush.no_c", 64'(out_valid1 || out_valid0), 64'(0));
      cycle();
    end

    // Stall build full: in_ready tracks out_ready combinationally.
    drive(1'b1, 1'b0, 1'b0, 8'h51, 64'h51); cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    #1;
    chk("stall0.full_ready_lo", 64'(in_ready0), 64'(0));
    out_ready = 1'b1;
    #1;
    chk("stall0.full_ready_hi", 64'(in_ready0), 64'(1));
    cycle();

    // Asynchronous reset while the skid build holds two entries.
    drive(1'b1, 1'b0, 1'b0, 8'h41, 64'h41); cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h42, 64'h42); cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    #1;
    chk("pre_reset.in_ready1", 64'(in_ready1), 64'(0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset.out_valid1", 64'(out_valid1), 64'(0));
    chk("midreset.out_ctrl1", 64'(out_ctrl1), 64'(0));
    chk("midreset.in_ready1", 64'(in_ready1), 64'(1));
    chk("midreset.out_valid0", 64'(out_valid0), 64'(0));
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'h61, 64'h61); cycle();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 64'h0); cycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) != 0), CW'($urandom), {$urandom, $urandom});
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the datapath payload (ALU result, store data, PC+1, instruction).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the control payload (reg-file write, data-memory write, write-back select, store type).
REQ-003 SHALL have parameter SKID, default 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single-entry stall register.
REQ-004 SHALL have the port clk, input, 1: the single clock; all state updates on the posedge.
REQ-005 SHALL have the port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have the port in_valid, input, 1: the upstream stage presents an instruction.
REQ-007 SHALL have the port in_ready, output, 1: this stage accepts the upstream instruction this cycle.
REQ-008 SHALL have the port in_ctrl, input, CTRL_W: upstream control bits.
REQ-009 SHALL have the port in_data, input, DATA_W: upstream datapath payload.
REQ-010 SHALL have the port flush, input, 1: discard all held and incoming instructions (branch/exception kill).
REQ-011 SHALL have the port out_valid, output, 1: the downstream stage is presented an instruction.
REQ-012 SHALL have the port out_ready, input, 1: the downstream stage accepts this cycle.
REQ-013 SHALL have the port out_ctrl, output, CTRL_W: downstream control bits.
REQ-014 SHALL have the port out_data, output, DATA_W: downstream datapath payload.

Function
REQ-015 SHALL complete an input transfer when in_valid&&in_ready, and an output transfer when out_valid&&out_ready.
REQ-016 SHALL force out_ctrl to all-zero whenever out_valid=0, so a bubble never writes the register file or memory; out_data is don't-care then.
REQ-017 SHALL, with SKID=1, run the FSM EMPTY, ONE (main slot full) and TWO (main and skid slots full).
REQ-018 SHALL in EMPTY go to ONE on an input transfer, loading the main slot; otherwise stay in EMPTY.
REQ-019 SHALL in ONE take one of three actions: input and output together reload the main slot and stay in ONE; input only loads the skid slot and goes to TWO; output only goes to EMPTY.
REQ-020 SHALL in TWO, on output, move the skid slot to the main slot and go to ONE; in TWO, without output, hold.
REQ-021 SHALL with SKID=1 drive in_ready directly from a flop, equal to (state!=TWO), with no combinational path from out_ready.
REQ-022 SHALL with SKID=1 give latency of exactly 1 cycle from input transfer to out_valid when the stage is EMPTY.
REQ-023 SHALL with SKID=1 sustain a throughput of 1 transfer/cycle while out_ready=1.
REQ-024 SHALL with SKID=0 use a single slot with in_ready = !out_valid || out_ready (combinational), and reload on simultaneous input and output.
REQ-025 SHALL keep out_valid, out_ctrl and out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL on flush=1 go to EMPTY at the next edge, discard both slots, and ignore any same-cycle input transfer; flush has priority over every handshake.
REQ-027 SHALL drive in_ready=1 in the cycle after a flush.
REQ-028 SHALL, on the flush cycle itself, still let out_valid/out_ctrl show the current head; downstream qualifies those outputs with flush.
REQ-029 SHALL never drop, duplicate or reorder an instruction, except by flush.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=EMPTY, out_valid=0, out_ctrl=0 and in_ready=1 (SKID=1).
REQ-031 SHALL reset the slot data to zero.
REQ-032 SHALL make reset asserted mid-operation discard all content, matching a flush.
REQ-033 SHALL accept input transfers from the first posedge after rst_n deasserts.

Structure
REQ-034 SHALL put the FSM state enum (EMPTY/ONE/TWO) and the default DATA_W/CTRL_W constants in the shared package pipe_pkg.
REQ-035 SHALL implement each storage slot (ctrl plus data register with load enable and async clear) as the sub-module pipe_slot, instanced twice for SKID=1 and once for SKID=0.
REQ-036 SHALL let the EXE/MEM, ID/EXE and MEM/WB stages each instance this block with their own widths.

Verification
REQ-037 SHALL cover reset: rst_n=0 mid-TWO -> out_valid=0, out_ctrl=0x00 and in_ready=1 immediately, with no clock edge needed.
REQ-038 SHALL cover streaming: SKID=1, out_ready=1, in_valid=1 for data 1..8 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first input, with no bubbles.
REQ-039 SHALL cover backpressure: hold out_ready=0 while sending A then B -> in_ready falls after B (TWO), out_data=A holds stable; then out_ready=1 -> A, then B, on consecutive cycles, with in_ready=1 on the cycle B is presented.
REQ-040 SHALL cover flush: flush=1 in TWO with a same-cycle in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, and C is never output.
REQ-041 SHALL cover bubble masking: in_valid=0 with in_ctrl=0xFF -> out_ctrl stays 0x00 throughout.
REQ-042 SHALL cover the SKID=0 build: repeat the streaming and backpressure sequences -> the same output order, and in_ready follows out_ready in the same cycle when full.
